// File: rtl/instr_prefetch_buffer.sv
// rtl/instr_prefetch_buffer.sv - sequential instruction prefetch buffer with redirect flush
module instr_prefetch_buffer #(
  parameter int                    ADDR_WIDTH  = 64,
  parameter int                    INSTR_WIDTH = 32,
  parameter int                    DEPTH       = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  i_redirect_pc,
  input  logic                   i_ready,
  output logic                   o_valid,
  output logic [INSTR_WIDTH-1:0] o_instruction,
  output logic [ADDR_WIDTH-1:0]  o_pc,
  output logic                   o_mem_req_valid,
  output logic [ADDR_WIDTH-1:0]  o_mem_req_addr,
  input  logic                   i_mem_req_ready,
  input  logic                   i_mem_resp_valid,
  input  logic [INSTR_WIDTH-1:0] i_mem_resp_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Fetch address and issue enable (held off until the first edge after reset)
  logic [ADDR_WIDTH-1:0]  r_fetch_pc;
  logic                   r_started;

  // Instruction FIFO and response-pc queue
  logic [INSTR_WIDTH-1:0] r_instr_mem [DEPTH];
  logic [ADDR_WIDTH-1:0]  r_pc_mem    [DEPTH];
  logic [ADDR_WIDTH-1:0]  r_resp_pc   [DEPTH];
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [PW-1:0]          r_q_wr;
  logic [PW-1:0]          r_q_rd;
  logic [CW-1:0]          r_count;
  logic [CW-1:0]          r_outstanding;
  logic [CW-1:0]          r_drop;

  logic [CW-1:0]          w_live;
  logic [CW:0]            w_occupied;
  logic                   w_req_valid;
  logic                   w_req_hs;
  logic                   w_pop;
  logic                   w_fifo_wr;
  logic [CW-1:0]          w_outstanding_next;
  logic                   w_unused;

  assign w_unused   = ^i_redirect_pc[1:0];

  // Credit: buffered plus live in-flight words must leave room in the FIFO.
  // The outstanding cap also bounds stale requests so the drop count never
  // exceeds DEPTH across back-to-back redirects.
  assign w_live      = r_outstanding - r_drop;
  assign w_occupied  = {1'b0, r_count} + {1'b0, w_live};
  assign w_req_valid = r_started && (w_occupied < {1'b0, DEPTH_C}) && (r_outstanding < DEPTH_C);
  assign w_req_hs    = w_req_valid & i_mem_req_ready;
  assign w_pop       = (r_count != '0) & i_ready;
  assign w_fifo_wr   = i_mem_resp_valid & ~i_redirect_valid & (r_drop == '0);

  assign w_outstanding_next = r_outstanding + {{(CW-1){1'b0}}, w_req_hs}
                                            - {{(CW-1){1'b0}}, i_mem_resp_valid};

  assign o_mem_req_valid = w_req_valid;
  assign o_mem_req_addr  = r_fetch_pc;
  assign o_valid         = (r_count != '0);
  assign o_instruction   = r_instr_mem[r_rd_ptr];
  assign o_pc            = r_pc_mem[r_rd_ptr];

  // Control state: fetch pc, pointers, occupancy, in-flight and stale counts
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      r_fetch_pc    <= RESET_PC;
      r_started     <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_q_wr        <= '0;
      r_q_rd        <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_started     <= 1'b1;
      r_outstanding <= w_outstanding_next;
      if (i_redirect_valid) begin
        // Everything in flight, including a request accepted now, turns stale
        r_fetch_pc <= {i_redirect_pc[ADDR_WIDTH-1:2], 2'b00};
        r_drop     <= w_outstanding_next;
        r_count    <= '0;
        r_rd_ptr   <= r_wr_ptr;
        r_q_rd     <= r_q_wr;
      end else begin
        if (w_req_hs) begin
          r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(4);
          r_q_wr     <= r_q_wr + 1'b1;
        end
        if (i_mem_resp_valid) begin
          if (r_drop != '0) r_drop <= r_drop - 1'b1;
          else              r_q_rd <= r_q_rd + 1'b1;
        end
        if (w_fifo_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_fifo_wr, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Storage: FIFO entries and pc of each live outstanding request
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_instr_mem[i] <= '0;
        r_pc_mem[i]    <= '0;
        r_resp_pc[i]   <= '0;
      end
    end else begin
      if (w_fifo_wr) begin
        r_instr_mem[r_wr_ptr] <= i_mem_resp_data;
        r_pc_mem[r_wr_ptr]    <= r_resp_pc[r_q_rd];
      end
      if (w_req_hs && !i_redirect_valid) begin
        r_resp_pc[r_q_wr] <= r_fetch_pc;
      end
    end
  end

`ifndef SYNTHESIS
  // A response must never land in a full FIFO unless an entry leaves in the same cycle
  always @(posedge i_clk) begin
    if (i_arst && w_fifo_wr && !w_pop) begin
      assert (r_count < DEPTH_C);
    end
  end
`endif

endmodule

// File: doc/instr_prefetch_buffer.md
Name: instr_prefetch_buffer

Overview:
- Instruction-supply front end that sits directly upstream of the pipeline's fetch stage.
- Issues sequential word fetches to an instruction memory over a valid/ready request channel, then buffers in-order responses in a small FIFO.
- Delivers {instruction, pc} pairs to the fetch stage over a valid/ready handshake.
- On a taken branch/jump redirect from execute (pc_src/pc_target), flushes buffered words and discards responses still in flight.

Parameters:
ADDR_WIDTH, 64, width of pc and memory address
INSTR_WIDTH, 32, width of an instruction word
DEPTH, 4, FIFO entries and maximum outstanding requests; power of 2, >= 2
RESET_PC, 0, first fetch address after reset; must be 4-byte aligned

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_arst  input  1  asynchronous reset, active-low (0 = reset)
i_redirect_valid  input  1  taken branch/jump in execute
i_redirect_pc  input  ADDR_WIDTH  redirect target; bits [1:0] ignored (treated as 0)
i_ready  input  1  fetch stage accepts the current output (deasserted while the fetch stage is stalled)
o_valid  output  1  o_instruction/o_pc hold a valid entry
o_instruction  output  INSTR_WIDTH  instruction at FIFO head
o_pc  output  ADDR_WIDTH  address of o_instruction
o_mem_req_valid  output  1  fetch request valid
o_mem_req_addr  output  ADDR_WIDTH  fetch address, word aligned
i_mem_req_ready  input  1  memory accepts request
i_mem_resp_valid  input  1  response data valid; in order, never backpressured
i_mem_resp_data  input  INSTR_WIDTH  response instruction word

Behaviour:
State and reset
- State elements: fetch_pc; FIFO of DEPTH entries of {instr, pc} with wr_ptr, rd_ptr and count; outstanding counter (0..DEPTH); drop counter (0..DEPTH); response-pc queue of DEPTH entries (pc of each live outstanding request).
- While i_arst=0, all of the following hold: fetch_pc=RESET_PC, pointers/counts/outstanding/drop=0, o_valid=0, o_mem_req_valid=0, o_mem_req_addr=RESET_PC, o_instruction=0, o_pc=0.
- Reset asserted mid-operation aborts everything. Responses arriving after reset release belong to pre-reset requests; memory is required to be reset together with this block, so the block does not filter them.

Request issue
- Request handshake completes when o_mem_req_valid & i_mem_req_ready.
- live = outstanding - drop. o_mem_req_valid is driven from registered state only: asserted when count + live < DEPTH. It never depends combinationally on i_redirect_valid or i_ready.
- o_mem_req_addr = fetch_pc. It is held stable while valid and not ready.
- On request handshake: fetch_pc += 4, wrapping modulo 2^ADDR_WIDTH; outstanding += 1; pc pushed to the response-pc queue.
- First request is visible the first cycle after reset release.

Response
- On i_mem_resp_valid: outstanding -= 1.
- If drop > 0: drop -= 1 and the data is discarded.
- Otherwise {data, queued pc} is written into the FIFO.
- The count + live < DEPTH credit rule guarantees the FIFO never overflows. A write into a full FIFO is a design error, covered by an assertion.

Output
- o_valid = (count != 0); o_instruction/o_pc = FIFO head.
- No bypass: a response is visible on the outputs the cycle after it is written. Minimum latency from request handshake to o_valid is therefore memory latency + 1.
- Pop when o_valid & i_ready.
- Simultaneous push and pop in the same cycle leaves count unchanged, including when the FIFO is full.

Redirect (priority over everything else in the same cycle)
- FIFO cleared: count=0, rd_ptr=wr_ptr. o_valid=0 next cycle. Any pop in this cycle has no further effect.
- fetch_pc = {i_redirect_pc[ADDR_WIDTH-1:2], 2'b00}.
- drop = outstanding_next - 0, where outstanding_next includes a request accepted in this same cycle and excludes a response arriving in this same cycle. All of those requests become stale. A response arriving in the redirect cycle is itself discarded, not written.
- Response-pc queue is cleared.
- A request handshake in the redirect cycle uses the old fetch_pc and counts as stale.
- Back-to-back redirects: each recomputes drop from the current outstanding count; the last target wins.

Test Plan:
1. Reset, DEPTH=4, RESET_PC=0, i_mem_req_ready=1, 1-cycle response latency, i_ready=1 -> requests at 0x0,0x4,0x8,...; outputs pc 0x0,0x4,0x8 in order with matching data, one per cycle in steady state.
2. As (1) with i_ready=0 -> exactly 4 requests issued (0x0..0xC), then o_mem_req_valid=0; FIFO holds 4 entries. Raising i_ready drains pc 0x0..0xC with no loss or duplication; fetching resumes at 0x10.
3. 3-cycle memory latency, 2 requests outstanding (0x20,0x24), redirect to 0x103 -> both responses discarded; next o_pc=0x100; next request address 0x100.
4. Redirect in the same cycle as a response and an i_ready pop -> response discarded, o_valid=0 next cycle, first post-redirect output pc equals the redirect target.
5. i_mem_req_ready=0 for 5 cycles with fetch_pc=0x40 -> o_mem_req_valid stays 1 and o_mem_req_addr stays 0x40 throughout.
6. i_arst=0 pulsed while FIFO holds 3 entries and 1 request is outstanding -> outputs return to reset values immediately; after release the first request is to RESET_PC and the first output has o_pc=RESET_PC.
